// File: rtl/ring_counter_pkg.sv
// ---------------------------------------------------------------------------
// ring_counter_pkg
// Shared constants and helpers for the parametrised ring/Johnson counter.
//   MODE_RING / MODE_JOHNSON : encodings of the mode input
//   DIR_LEFT  / DIR_RIGHT    : encodings of the dir input
//   base_of(mode, w)         : home pattern for a mode, LSB-aligned. Callers
//                              size-cast the result to their own width.
// ---------------------------------------------------------------------------
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    localparam int BASE_MAX_W = 64;

    // Ring home is one-hot at bit 0, Johnson home is all zeros. Only bit 0
    // can ever be set, so the fixed return width is no limit on w: a wider
    // counter zero-extends the result.
    function automatic logic [BASE_MAX_W-1:0] base_of(input logic mode, input int w);
        logic [BASE_MAX_W-1:0] b;
        b = '0;
        if (mode == MODE_RING && w >= 1) begin
            b[0] = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/ring_state_check.sv
// ---------------------------------------------------------------------------
// ring_state_check
// Combinational legality check of a counter state for the selected mode.
//   q_i     [W-1:0] in  : counter state
//   mode_i          in  : 0 = ring, 1 = Johnson
//   legal_o         out : 1 when q_i is a reachable state of that mode
// Ring legal    : exactly one bit set.
// Johnson legal : at most one adjacent-bit transition, i.e. a single run of
//                 ones anchored at either end (all-0 and all-1 included).
// ---------------------------------------------------------------------------
module ring_state_check
    import ring_counter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] q_i,
    input  logic         mode_i,
    output logic         legal_o
);

    // edge_w[i] marks a transition between neighbouring bits i and i+1.
    logic [W-2:0] edge_w;

    genvar gi;
    generate
        for (gi = 0; gi < W - 1; gi++) begin : g_edge
            assign edge_w[gi] = q_i[gi] ^ q_i[gi+1];
        end
    endgenerate

    always_comb begin
        legal_o = 1'b0;
        if (mode_i == MODE_RING) begin
            legal_o = ($countones(q_i) == 1);
        end else begin
            legal_o = ($countones(edge_w) <= 1);
        end
    end

endmodule

// File: rtl/ring_counter_param.sv
// ---------------------------------------------------------------------------
// ring_counter_param
// W-bit shift-register counter, one-hot ring or Johnson, either direction,
// with count enable, parallel load, illegal-state self-correction and a
// one-cycle wrap pulse.
//   c_i            in  : clock, rising edge
//   r_i            in  : synchronous reset, active low (q <= home pattern)
//   en_i           in  : advance one step per cycle
//   mode_i         in  : 0 = ring, 1 = Johnson
//   dir_i          in  : 0 = shift toward MSB, 1 = shift toward LSB
//   ld_i           in  : parallel load strobe (beats en_i)
//   d_i    [W-1:0] in  : parallel load value, taken verbatim
//   q_o    [W-1:0] out : counter state, registered
//   wrap_o         out : registered, high in the cycle a count step lands on home
//   err_o          out : combinational, high while q_o is illegal for mode_i
// ---------------------------------------------------------------------------
module ring_counter_param
    import ring_counter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         c_i,
    input  logic         r_i,
    input  logic         en_i,
    input  logic         mode_i,
    input  logic         dir_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         wrap_o,
    output logic         err_o
);

    logic [W-1:0] q_q, q_d;
    logic         wrap_q, wrap_d;
    logic [W-1:0] base;
    logic [W-1:0] shifted;
    logic         fb;
    logic         legal;

    assign base = W'(base_of(mode_i, W));

    ring_state_check #(.W(W)) u_check (
        .q_i     (q_q),
        .mode_i  (mode_i),
        .legal_o (legal)
    );

    // The bit shifted in is the bit shifted out, inverted in Johnson mode.
    always_comb begin
        fb      = 1'b0;
        shifted = q_q;
        if (dir_i == DIR_LEFT) begin
            fb      = q_q[W-1] ^ (mode_i == MODE_JOHNSON);
            shifted = {q_q[W-2:0], fb};
        end else begin
            fb      = q_q[0] ^ (mode_i == MODE_JOHNSON);
            shifted = {fb, q_q[W-1:1]};
        end
    end

    // Load beats count; a count step from an illegal state snaps to home
    // instead of shifting, and never raises wrap.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (ld_i) begin
            q_d = d_i;
        end else if (en_i) begin
            if (!legal) begin
                q_d = base;
            end else begin
                q_d    = shifted;
                wrap_d = (shifted == base);
            end
        end
    end

    always_ff @(posedge c_i) begin
        if (!r_i) begin
            q_q    <= base;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q_o    = q_q;
    assign wrap_o = wrap_q;
    assign err_o  = ~legal;

endmodule
